thermo_pwm_array: RTL and testbench

THERMO_PWM_ARRAY -- requirements
Module: thermo_pwm_array

---
 rtl/thermo_pwm_array_pkg.sv | 17 +
 rtl/thermo_pwm_array_pwm_channel.sv | 51 +++++
 rtl/thermo_pwm_array.sv | 80 ++++++++
 tb/tb_thermo_pwm_array.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/thermo_pwm_array_pkg.sv
// Shared defaults and helpers for the thermometer-coded PWM array.
// Used by the RTL and by its bench so both agree on sizes.
package thermo_pwm_array_pkg;

  localparam int DEF_WIDTH    = 3;
  localparam int DEF_CHANNELS = 4;

  // Width of a channel index; a single channel still needs one select bit.
  function automatic int ch_idx_w(input int channels);
    if (channels > 1) begin
      return $clog2(channels);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/thermo_pwm_array_pwm_channel.sv
// One PWM channel: active duty register, double-buffered shadow with a pending flag,
// and the thermometer compare against the shared counter.
module pwm_channel
  import thermo_pwm_array_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             en,
  input  logic             ch_en,
  input  logic             wrap,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_duty,
  input  logic [WIDTH-1:0] count,
  output logic             pwm,
  output logic             pending
);

  logic [WIDTH-1:0] active_r;
  logic [WIDTH-1:0] shadow_r;
  logic             pending_r;

  // Duty storage: immediate load when idle or on the wrap edge, otherwise deferred to wrap.
  always_ff @(posedge clock) begin
    if (clear) begin
      active_r  <= {WIDTH{1'b0}};
      shadow_r  <= {WIDTH{1'b0}};
      pending_r <= 1'b0;
    end else if (wr) begin
      // A write is only ever granted while pending is clear.
      if (!en || wrap) begin
        active_r <= wr_duty;
      end else begin
        shadow_r  <= wr_duty;
        pending_r <= 1'b1;
      end
    end else if (wrap && pending_r) begin
      active_r  <= shadow_r;
      pending_r <= 1'b0;
    end else begin
      active_r  <= active_r;
      shadow_r  <= shadow_r;
      pending_r <= pending_r;
    end
  end

  assign pwm     = en & ch_en & (count <= active_r);
  assign pending = pending_r;

endmodule

// File: rtl/thermo_pwm_array.sv
// Multi-channel PWM: a shared free-running period counter plus write decode,
// feeding CHANNELS independent thermometer-duty channels.
module thermo_pwm_array
  import thermo_pwm_array_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS
) (
  input  logic                          clock,
  input  logic                          clear,
  input  logic                          en,
  input  logic [CHANNELS-1:0]           ch_en,
  input  logic                          wr_valid,
  input  logic [ch_idx_w(CHANNELS)-1:0] wr_ch,
  input  logic [WIDTH-1:0]              wr_duty,
  output logic                          wr_ready,
  output logic [WIDTH-1:0]              count,
  output logic                          wrap,
  output logic [CHANNELS-1:0]           pwm_out
);

  logic [WIDTH-1:0]    count_r;
  logic                wrap_s;
  logic                wr_ready_s;
  logic [CHANNELS-1:0] wr_sel_s;
  logic [CHANNELS-1:0] pending_s;

  // Period counter: advances while enabled, holds otherwise.
  always_ff @(posedge clock) begin
    if (clear) begin
      count_r <= {WIDTH{1'b0}};
    end else if (en) begin
      count_r <= count_r + WIDTH'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign wrap_s = en & (count_r == {WIDTH{1'b1}});

  // Write decode; an index with no matching channel leaves ready low.
  always_comb begin
    wr_ready_s = 1'b0;
    wr_sel_s   = {CHANNELS{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      if (int'(wr_ch) == c) begin
        wr_ready_s = ~pending_s[c];
      end else begin
        wr_ready_s = wr_ready_s;
      end
    end
    for (int c = 0; c < CHANNELS; c++) begin
      if (wr_valid && wr_ready_s && (int'(wr_ch) == c)) begin
        wr_sel_s[c] = 1'b1;
      end else begin
        wr_sel_s[c] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pwm_channel #(.WIDTH(WIDTH)) u_ch (
      .clock   (clock),
      .clear   (clear),
      .en      (en),
      .ch_en   (ch_en[g]),
      .wrap    (wrap_s),
      .wr      (wr_sel_s[g]),
      .wr_duty (wr_duty),
      .count   (count_r),
      .pwm     (pwm_out[g]),
      .pending (pending_s[g])
    );
  end

  assign wr_ready = wr_ready_s;
  assign count    = count_r;
  assign wrap     = wrap_s;

endmodule

// File: tb/tb_thermo_pwm_array.sv
// Directed bench for thermo_pwm_array at WIDTH=3, CHANNELS=4: a per-cycle vector
// table with hand-computed expectations, plus reset and bounded-wrap sequences.
module tb_thermo_pwm_array;
  import thermo_pwm_array_pkg::*;

  localparam int W  = 3;
  localparam int CH = 4;
  localparam int CW = ch_idx_w(CH);

  logic          clock;
  logic          clear;
  logic          en;
  logic [CH-1:0] ch_en;
  logic          wr_valid;
  logic [CW-1:0] wr_ch;
  logic [W-1:0]  wr_duty;
  logic          wr_ready;
  logic [W-1:0]  count;
  logic          wrap;
  logic [CH-1:0] pwm_out;

  thermo_pwm_array #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clock    (clock),
    .clear    (clear),
    .en       (en),
    .ch_en    (ch_en),
    .wr_valid (wr_valid),
    .wr_ch    (wr_ch),
    .wr_duty  (wr_duty),
    .wr_ready (wr_ready),
    .count    (count),
    .wrap     (wrap),
    .pwm_out  (pwm_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic          clr;
    logic          en;
    logic [CH-1:0] ch_en;
    logic          wv;
    logic [CW-1:0] wch;
    logic [W-1:0]  wd;
    logic [W-1:0]  cnt;
    logic          wrp;
    logic [CH-1:0] pwm;
    logic          rdy;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic clr_i, input logic en_i, input logic [3:0] chen_i,
                     input logic wv_i, input logic [1:0] wch_i, input logic [2:0] wd_i,
                     input logic [2:0] cnt_i, input logic wrp_i, input logic [3:0] pwm_i,
                     input logic rdy_i);
    vec_t v;
    v.clr = clr_i; v.en = en_i; v.ch_en = chen_i; v.wv = wv_i; v.wch = wch_i; v.wd = wd_i;
    v.cnt = cnt_i; v.wrp = wrp_i; v.pwm = pwm_i; v.rdy = rdy_i;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    bit found;

    // Power-up clear while en is requested: clear must win
    clear = 1'b1; en = 1'b1; ch_en = 4'hF; wr_valid = 1'b0; wr_ch = 2'd0; wr_duty = 3'd0;
    @(posedge clock);
    @(negedge clock);
    #1;
    chk("reset_count", 8'(count), 8'd0);
    chk("reset_pwm", 8'(pwm_out), 8'h0F);
    chk("reset_wrap", 8'(wrap), 8'd0);
    chk("reset_ready", 8'(wr_ready), 8'd1);
    @(posedge clock);

    // Duty 0 everywhere: high only at count 0, wrap at 7
    add(0,1,4'hF,0,0,0, 0,0,4'hF,1);
    for (int i = 1; i < 7; i++) add(0,1,4'hF,0,0,0, 3'(i),0,4'h0,1);
    add(0,1,4'hF,0,0,0, 7,1,4'h0,1);
    // Idle write to ch1 lands directly, visible from the first period
    add(0,0,4'hF,1,1,3, 0,0,4'h0,1);
    add(0,1,4'hF,0,1,0, 0,0,4'hF,1);
    for (int i = 1; i < 4; i++) add(0,1,4'hF,0,1,0, 3'(i),0,4'h2,1);
    for (int i = 4; i < 7; i++) add(0,1,4'hF,0,1,0, 3'(i),0,4'h0,1);
    add(0,1,4'hF,0,1,0, 7,1,4'h0,1);
    // Running write to ch2 at count 2 is deferred; a second write is ignored
    add(0,1,4'hF,0,2,0, 0,0,4'hF,1);
    add(0,1,4'hF,0,2,0, 1,0,4'h2,1);
    add(0,1,4'hF,1,2,7, 2,0,4'h2,1);
    add(0,1,4'hF,0,2,0, 3,0,4'h2,0);
    add(0,1,4'hF,1,2,1, 4,0,4'h0,0);
    add(0,1,4'hF,0,2,0, 5,0,4'h0,0);
    add(0,1,4'hF,0,2,0, 6,0,4'h0,0);
    add(0,1,4'hF,0,2,0, 7,1,4'h0,0);
    add(0,1,4'hF,0,2,0, 0,0,4'hF,1);
    for (int i = 1; i < 4; i++) add(0,1,4'hF,0,2,0, 3'(i),0,4'h6,1);
    for (int i = 4; i < 7; i++) add(0,1,4'hF,0,2,0, 3'(i),0,4'h4,1);
    add(0,1,4'hF,0,2,0, 7,1,4'h4,1);
    // Clear at count 5 with ch2 pending, plus a same-cycle ch3 write that must be lost
    add(0,1,4'hF,1,2,3, 0,0,4'hF,1);
    for (int i = 1; i < 4; i++) add(0,1,4'hF,0,2,0, 3'(i),0,4'h6,0);
    add(0,1,4'hF,0,2,0, 4,0,4'h4,0);
    add(1,1,4'hF,1,3,5, 5,0,4'h4,1);
    add(0,1,4'hF,0,2,0, 0,0,4'hF,1);
    add(0,1,4'hF,0,3,0, 1,0,4'h0,1);
    for (int i = 2; i < 7; i++) add(0,1,4'hF,0,2,0, 3'(i),0,4'h0,1);
    add(0,1,4'hF,0,2,0, 7,1,4'h0,1);
    add(0,1,4'hF,0,2,0, 0,0,4'hF,1);
    add(0,1,4'hF,0,2,0, 1,0,4'h0,1);
    // en dropped at count 4 holds the counter and silences outputs
    add(0,0,4'hF,1,0,5, 2,0,4'h0,1);
    add(0,1,4'hF,0,0,0, 2,0,4'h1,1);
    add(0,1,4'hF,0,0,0, 3,0,4'h1,1);
    add(0,0,4'hF,0,0,0, 4,0,4'h0,1);
    add(0,0,4'hF,0,0,0, 4,0,4'h0,1);
    add(0,1,4'hF,0,0,0, 4,0,4'h1,1);
    add(0,1,4'hF,0,0,0, 5,0,4'h1,1);
    add(0,1,4'hF,0,0,0, 6,0,4'h0,1);
    // Write on the wrap cycle loads active directly; channel mask applied
    add(0,1,4'hF,1,3,2, 7,1,4'h0,1);
    add(0,1,4'hF,0,3,0, 0,0,4'hF,1);
    add(0,1,4'hF,0,3,0, 1,0,4'h9,1);
    add(0,1,4'h5,0,3,0, 2,0,4'h1,1);
    add(0,1,4'h5,0,3,0, 3,0,4'h1,1);
    // Pending survives an en gap and commits at the next running wrap
    add(0,1,4'hF,1,1,6, 4,0,4'h1,1);
    add(0,0,4'hF,0,1,0, 5,0,4'h0,0);
    add(0,0,4'hF,0,1,0, 5,0,4'h0,0);
    add(0,1,4'hF,0,1,0, 5,0,4'h1,0);
    add(0,1,4'hF,0,1,0, 6,0,4'h0,0);
    add(0,1,4'hF,0,1,0, 7,1,4'h0,0);
    add(0,1,4'hF,0,1,0, 0,0,4'hF,1);
    add(0,1,4'hF,0,1,0, 1,0,4'hB,1);
    add(0,1,4'hF,0,1,0, 2,0,4'hB,1);
    add(0,1,4'hF,0,1,0, 3,0,4'h3,1);

    foreach (tbl[k]) begin
      @(negedge clock);
      clear = tbl[k].clr; en = tbl[k].en; ch_en = tbl[k].ch_en;
      wr_valid = tbl[k].wv; wr_ch = tbl[k].wch; wr_duty = tbl[k].wd;
      #1;
      chk($sformatf("v%0d_count", k), 8'(count), 8'(tbl[k].cnt));
      chk($sformatf("v%0d_wrap", k), 8'(wrap), 8'(tbl[k].wrp));
      chk($sformatf("v%0d_pwm", k), 8'(pwm_out), 8'(tbl[k].pwm));
      chk($sformatf("v%0d_ready", k), 8'(wr_ready), 8'(tbl[k].rdy));
    end

    // Free-run to the next wrap under a cycle budget; it must appear at count 7
    found = 1'b0;
    for (int n = 0; n < 16 && !found; n++) begin
      @(negedge clock);
      clear = 1'b0; en = 1'b1; ch_en = 4'hF; wr_valid = 1'b0;
      #1;
      if (wrap === 1'b1) begin
        found = 1'b1;
        chk("wrap_at_count", 8'(count), 8'd7);
      end
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL wrap_timeout: got no wrap expected wrap within 16 cycles");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
